// File: rtl/exp_pipe_calculator.sv
// Four-stage, multi-lane fixed-point e^x evaluator. Range reduction x*log2e = k + f,
// then a quadratic polynomial in r = f*ln2, then a saturating shift by k.
module exp_pipe_calculator #(
   parameter int LANES     = 4,
   parameter int BITWIDTH  = 16,
   parameter int FRAC_BITS = 10,
   parameter int C0        = 1024,
   parameter int C1        = 993,
   parameter int C2        = 368,
   parameter int LOG2E     = 1477,
   parameter int LN2       = 710
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [LANES*BITWIDTH-1:0] in_p,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [LANES*BITWIDTH-1:0] out_l_p,
   output logic [LANES-1:0]          out_sat
);

   localparam int PW = BITWIDTH + 16;

   localparam logic signed [PW-1:0] K_LOG2E = PW'(LOG2E);
   localparam logic signed [PW-1:0] K_LN2   = PW'(LN2);
   localparam logic signed [PW-1:0] K_C0    = PW'(C0);
   localparam logic signed [PW-1:0] K_C1    = PW'(C1);
   localparam logic signed [PW-1:0] K_C2    = PW'(C2);
   localparam logic signed [PW-1:0] K_ROUND = PW'((1 << FRAC_BITS) - 1);
   localparam logic signed [PW-1:0] K_BW    = PW'(BITWIDTH);
   localparam logic signed [PW-1:0] K_MAX   = {{(PW-BITWIDTH){1'b0}}, {BITWIDTH{1'b1}}};
   localparam logic signed [PW-1:0] K_OVF   = K_MAX + PW'(1);

   // Valid/ready: the whole pipe moves together whenever the output register is
   // empty or being taken; an input transfers on in_valid & in_ready.
   logic w_advance;
   logic r_v1, r_v2, r_v3, r_v4;

   assign w_advance = !r_v4 || out_ready;
   assign in_ready  = w_advance;
   assign out_valid = r_v4;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_v1 <= 1'b0;
         r_v2 <= 1'b0;
         r_v3 <= 1'b0;
         r_v4 <= 1'b0;
      end else if (w_advance) begin
         r_v1 <= in_valid;
         r_v2 <= r_v1;
         r_v3 <= r_v2;
         r_v4 <= r_v3;
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      logic signed [BITWIDTH-1:0] w_x;
      logic signed [PW-1:0]       w_xe, w_y, w_k, w_f, w_r, w_t, w_p, w_pc, w_nk, w_v;
      logic [BITWIDTH-1:0]        w_res;
      logic                       w_sat;
      logic signed [PW-1:0]       r_k1, r_f1, r_k2, r_r2, r_k3, r_r3, r_t3;
      logic [BITWIDTH-1:0]        r_res4;
      logic                       r_sat4;

      assign w_x  = in_p[g*BITWIDTH +: BITWIDTH];
      assign w_xe = w_x;
      assign w_y  = (w_xe * K_LOG2E) >>> FRAC_BITS;
      assign w_k  = (w_y + K_ROUND) >>> FRAC_BITS;
      assign w_f  = w_y - (w_k <<< FRAC_BITS);
      assign w_r  = (r_f1 * K_LN2) >>> FRAC_BITS;
      assign w_t  = ((K_C2 * r_r2) >>> FRAC_BITS) + K_C1;
      assign w_p  = ((r_t3 * r_r3) >>> FRAC_BITS) + K_C0;
      assign w_pc = w_p[PW-1] ? '0 : w_p;
      assign w_nk = -r_k3;

      // Large positive k is resolved without shifting so the shift never wraps.
      always_comb begin
         w_v   = '0;
         w_sat = 1'b0;
         w_res = '0;
         if (!r_k3[PW-1]) begin
            if (r_k3 >= K_BW) w_v = (w_pc != '0) ? K_OVF : '0;
            else              w_v = w_pc << r_k3;
         end else if (w_nk < K_BW) begin
            w_v = w_pc >> w_nk;
         end
         if (w_v > K_MAX) begin
            w_sat = 1'b1;
            w_res = {BITWIDTH{1'b1}};
         end else begin
            w_res = w_v[BITWIDTH-1:0];
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            r_k1   <= '0;
            r_f1   <= '0;
            r_k2   <= '0;
            r_r2   <= '0;
            r_k3   <= '0;
            r_r3   <= '0;
            r_t3   <= '0;
            r_res4 <= '0;
            r_sat4 <= 1'b0;
         end else if (w_advance) begin
            r_k1   <= w_k;
            r_f1   <= w_f;
            r_k2   <= r_k1;
            r_r2   <= w_r;
            r_k3   <= r_k2;
            r_r3   <= r_r2;
            r_t3   <= w_t;
            r_res4 <= w_res;
            r_sat4 <= w_sat;
         end
      end

      assign out_l_p[g*BITWIDTH +: BITWIDTH] = r_res4;
      assign out_sat[g]                      = r_sat4;
   end

endmodule
